fetch_redirect: RTL
===================

# fetch_redirect

Fetch-side PC register and IF/ID pipeline register for the P6 five-stage MIPS pipeline. It consumes the ID-stage comparator flags (`larger`/`equal`/`smaller`) together with the decoded branch/jump opcode. It resolves control transfers in ID with one architectural delay slot and drives the next fetch address. It also owns the IF/ID register contents (`instr_d`, `pc_d`) and the link address used by `jal`/`jalr`.

## Interface
- `RESET_PC`, default 32'h0000_3000: value loaded into the PC on reset.
- `clk`  in  1: rising-edge clock.
- `reset`  in  1: asynchronous, active-high; clears all state immediately.
- `stall`  in  1: hazard-unit freeze of the F and D stages.
- `instr_f`  in  32: instruction memory word read at `pc_f`.
- `br_op_d`  in  4: branch/jump opcode of the instruction in D, from the ID decoder.
- `larger`, `equal`, `smaller`  in  1 each: comparator flags for `SrcA` versus `SrcB` in D.
- `rs_val_d`  in  32: forwarded GPR[rs] in D, used by `jr`/`jalr`.
- `pc_f`  out  32: current fetch address.
- `instr_d`  out  32: IF/ID instruction.
- `pc_d`  out  32: IF/ID PC.
- `pc8_d`  out  32: `pc_d + 8`, the link value.
- `valid_d`  out  1: IF/ID holds a fetched instruction (0 = reset bubble).
- `taken_d`  out  1: control transfer resolved taken this cycle.

## Operation
- Opcode encodings (`br_op_d`):
  - 0 `NONE`, 1 `BEQ`, 2 `BNE`, 3 `BLEZ`, 4 `BGTZ`, 5 `BLTZ`, 6 `BGEZ`
  - 7 `J`, 8 `JAL`, 9 `JR`, 10 `JALR`
  - 11–15 are reserved and behave as `NONE`.
- The ID-stage comparator `SrcB` mux selects GPR[rt] for `BEQ`/`BNE` and zero for all other branches. This block does no operand muxing.
- Taken conditions:
  - `BEQ`: `equal`
  - `BNE`: `!equal`
  - `BLEZ`: `smaller|equal`
  - `BGTZ`: `larger`
  - `BLTZ`: `smaller`
  - `BGEZ`: `larger|equal`
  - `J`, `JAL`, `JR`, `JALR`: always taken
  - `NONE`: never taken
- `taken_d` is forced to 0 when `valid_d = 0`.
- Target selection:
  - Branch target: `pc_d + 4 + (sext(instr_d[15:0]) << 2)`, modulo 2^32.
  - `J`/`JAL` target: `{pc4_d[31:28], instr_d[25:0], 2'b00}`, where `pc4_d = pc_d + 4`.
  - `JR`/`JALR` target: `rs_val_d` as given. No alignment check, no exception.
- `pc8_d = pc_d + 8`, combinational and always driven. The downstream writeback uses it only for `JAL`/`JALR`.
- Delay slot: the instruction at `pc_d + 4` is fetched in the same cycle the branch sits in D, and it is never squashed. There is no flush path.
- Next-PC rule: `npc = taken_d ? target : pc_f + 4`.

## Timing
- Reset (asynchronous): `pc_f = RESET_PC`, `pc_d = RESET_PC`, `instr_d = 0` (nop), `valid_d = 0`.
- Combinational outputs follow from this state: `taken_d = 0` and `pc8_d = RESET_PC + 8`.
- Each rising edge with `stall = 0`:
  - `pc_f <= npc`
  - `instr_d <= instr_f`
  - `pc_d <= pc_f`
  - `valid_d <= 1`
- Each rising edge with `stall = 1`: `pc_f`, `instr_d`, `pc_d` and `valid_d` all hold.
- Stall and taken in the same cycle: no redirect is committed. The decision is recomputed in the next cycle with the updated forwarded operands; only the flags present on the first non-stalled edge matter.
- Redirect latency: a branch resolved in D in cycle n produces `pc_f = target` in cycle n+1. The delay slot enters D in cycle n+1.
- `taken_d`, `pc8_d` and the target logic are purely combinational from state and inputs. There is no registered decision.
- Reset asserted mid-stream overrides `stall` and any pending redirect. The first fetch after deassertion is at `RESET_PC`.
- PC arithmetic is 32-bit and wraps silently (0xFFFF_FFFC + 4 = 0).

## Structure
- Shared package `p6_defs` holds `RESET_PC`, the `br_op` encodings, `NOP = 32'h0`, and `BR_OP_W = 4`. The ID decoder imports the same package.
- One natural sub-module, `npc_calc`, is combinational: it takes `pc_d`, `instr_d`, `br_op_d`, the flags and `rs_val_d`, and produces `taken_d` and the target.
- The PC register and IF/ID register live in the top module.

## Test plan
- Reset then 3 unstalled cycles → `pc_f` = 0x3000, 0x3004, 0x3008, 0x300C; `valid_d` goes 0→1 after the first edge; `pc_d` trails `pc_f` by one cycle.
- `BEQ` at 0x3004 with offset 0x0003 and `equal = 1` → delay slot 0x3008 enters D; next `pc_f` = 0x3014. Same case with `equal = 0` → `pc_f` continues at 0x300C.
- `BGEZ` with `smaller = 1`, then `BLEZ` with `equal = 1` → not taken, then taken. Negative offset 0xFFFF at `pc_d` 0x3010 → target 0x3010.
- `JAL` index 0x0000C10 at `pc_d` 0x3000 → `pc8_d` = 0x3008; next `pc_f` = 0x0000_3040.
- `JR` with `rs_val_d` = 0x3100 under `stall = 1` for 2 cycles, `rs_val_d` changing to 0x3200 before release → `pc_f` holds; after release `pc_f` = 0x3200.
- Reset asserted between edges while a taken branch is in D → `pc_f` = 0x3000 and `instr_d` = 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/p6_defs.sv
// Shared P6 pipeline definitions: reset vector, branch/jump opcode encodings, nop word.
// Imported by the fetch/redirect logic and by the ID decoder.
package p6_defs;

    localparam int          BR_OP_W  = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [31:0] NOP      = 32'h0000_0000;

    // Codes 11-15 are reserved and decode as BR_NONE.
    typedef enum logic [BR_OP_W-1:0] {
        BR_NONE = 4'd0,
        BR_BEQ  = 4'd1,
        BR_BNE  = 4'd2,
        BR_BLEZ = 4'd3,
        BR_BGTZ = 4'd4,
        BR_BLTZ = 4'd5,
        BR_BGEZ = 4'd6,
        BR_J    = 4'd7,
        BR_JAL  = 4'd8,
        BR_JR   = 4'd9,
        BR_JALR = 4'd10
    } br_op_e;

endpackage

// File: rtl/fetch_redirect_npc_calc.sv
// Combinational ID-stage control-transfer resolution: taken decision and redirect target.
// Caller is responsible for qualifying taken_o with the IF/ID valid bit.
module npc_calc
    import p6_defs::*;
(
    input  logic [31:0]        pc_d_i,
    input  logic [25:0]        instr_idx_i,
    input  logic [BR_OP_W-1:0] br_op_d_i,
    input  logic               larger_i,
    input  logic               equal_i,
    input  logic               smaller_i,
    input  logic [31:0]        rs_val_d_i,
    output logic               taken_o,
    output logic [31:0]        target_o
);

    logic [31:0] pc4;
    logic [31:0] br_target;
    logic [31:0] j_target;

    assign pc4       = pc_d_i + 32'd4;
    assign br_target = pc4 + {{14{instr_idx_i[15]}}, instr_idx_i[15:0], 2'b00};
    assign j_target  = {pc4[31:28], instr_idx_i, 2'b00};

    always_comb begin
        taken_o  = 1'b0;
        target_o = br_target;
        case (br_op_d_i)
            BR_BEQ:  taken_o = equal_i;
            BR_BNE:  taken_o = !equal_i;
            BR_BLEZ: taken_o = smaller_i | equal_i;
            BR_BGTZ: taken_o = larger_i;
            BR_BLTZ: taken_o = smaller_i;
            BR_BGEZ: taken_o = larger_i | equal_i;
            BR_J, BR_JAL: begin
                taken_o  = 1'b1;
                target_o = j_target;
            end
            BR_JR, BR_JALR: begin
                taken_o  = 1'b1;
                target_o = rs_val_d_i;
            end
            default: taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/fetch_redirect.sv
// Fetch PC register and IF/ID pipeline register with ID-stage redirect (one delay slot, no flush).
// Stall freezes both stages; a taken decision under stall is simply re-evaluated next cycle.
module fetch_redirect
    import p6_defs::*;
#(
    parameter logic [31:0] RESET_PC = p6_defs::RESET_PC
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic [31:0]        instr_f,
    input  logic [BR_OP_W-1:0] br_op_d,
    input  logic               larger,
    input  logic               equal,
    input  logic               smaller,
    input  logic [31:0]        rs_val_d,
    output logic [31:0]        pc_f,
    output logic [31:0]        instr_d,
    output logic [31:0]        pc_d,
    output logic [31:0]        pc8_d,
    output logic               valid_d,
    output logic               taken_d
);

    logic [31:0] pc_f_q,    pc_f_d;
    logic [31:0] pc_d_q,    pc_d_d;
    logic [31:0] instr_d_q, instr_d_d;
    logic        valid_d_q, valid_d_d;

    logic        taken_raw;
    logic [31:0] target;

    npc_calc u_npc_calc (
        .pc_d_i      (pc_d_q),
        .instr_idx_i (instr_d_q[25:0]),
        .br_op_d_i   (br_op_d),
        .larger_i    (larger),
        .equal_i     (equal),
        .smaller_i   (smaller),
        .rs_val_d_i  (rs_val_d),
        .taken_o     (taken_raw),
        .target_o    (target)
    );

    // The reset bubble in D must never redirect, whatever the decoder presents.
    assign taken_d = valid_d_q & taken_raw;
    assign pc8_d   = pc_d_q + 32'd8;

    always_comb begin
        pc_f_d    = pc_f_q;
        pc_d_d    = pc_d_q;
        instr_d_d = instr_d_q;
        valid_d_d = valid_d_q;
        if (!stall) begin
            pc_f_d    = taken_d ? target : pc_f_q + 32'd4;
            pc_d_d    = pc_f_q;
            instr_d_d = instr_f;
            valid_d_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_f_q    <= RESET_PC;
            pc_d_q    <= RESET_PC;
            instr_d_q <= NOP;
            valid_d_q <= 1'b0;
        end else begin
            pc_f_q    <= pc_f_d;
            pc_d_q    <= pc_d_d;
            instr_d_q <= instr_d_d;
            valid_d_q <= valid_d_d;
        end
    end

    assign pc_f    = pc_f_q;
    assign pc_d    = pc_d_q;
    assign instr_d = instr_d_q;
    assign valid_d = valid_d_q;

endmodule
